// File: rtl/vga_pixel_encoder.sv
// RGB444 -> RGB111 streaming encoder with raster address generation and a
// single-entry output register feeding the frame-buffer write port.
module vga_pixel_encoder #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 120,
  parameter int ADDR_W   = 15,
  parameter int THRESH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:0]       in_pixel,
  input  logic              in_sof,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int                NPIX      = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  // Five bits so that a threshold of 16 (never set) still compares correctly.
  localparam logic [4:0]        THR       = 5'(THRESH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pix_cnt, pix_cnt_nxt;
  logic [ADDR_W-1:0] load_addr;
  logic              accept, load, err, wr_done;

  function automatic logic [2:0] quantize(input logic [11:0] px);
    return {({1'b0, px[11:8]} >= THR),
            ({1'b0, px[7:4]}  >= THR),
            ({1'b0, px[3:0]}  >= THR)};
  endfunction

  assign in_ready = !wr_en || wr_ready;
  assign accept   = in_valid && in_ready;
  assign wr_done  = wr_en && wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pix_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pix_cnt <= pix_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_sof) begin
        state_nxt = (LAST_ADDR == '0) ? IDLE : ACTIVE;
      end else if (state == ACTIVE && pix_cnt == LAST_ADDR) begin
        state_nxt = IDLE;
      end
    end
  end

  // Pixels outside a frame are dropped; an sof always restarts at address 0.
  always_comb begin
    load        = accept && (in_sof || state == ACTIVE);
    err         = accept && in_sof && state == ACTIVE;
    load_addr   = in_sof ? '0 : pix_cnt;
    pix_cnt_nxt = pix_cnt;
    if (load) begin
      pix_cnt_nxt = (load_addr == LAST_ADDR) ? '0 : load_addr + ADDR_W'(1);
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      if (load) begin
        wr_en   <= 1'b1;
        wr_addr <= load_addr;
        wr_data <= quantize(in_pixel);
      end else if (wr_done) begin
        wr_en <= 1'b0;
      end
      frame_done <= wr_done && (wr_addr == LAST_ADDR);
      sync_err   <= err;
    end
  end

endmodule

// File: tb/tb_vga_pixel_encoder.sv
// Randomized bench for vga_pixel_encoder on a 4x2 raster, checked against a
// frame-position model and an expected-write queue.
module tb_vga_pixel_encoder;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int AW   = 3;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          wr_ready = 1'b1;
  logic [11:0]   in_pixel = 12'h000;
  logic          in_ready, wr_en, frame_done, sync_err;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          in_ready12, wr_en12, frame_done12, sync_err12;
  logic [AW-1:0] wr_addr12;
  logic [2:0]    wr_data12;

  vga_pixel_encoder #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .THRESH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done), .sync_err(sync_err)
  );

  vga_pixel_encoder #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .THRESH(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .in_pixel(in_pixel), .in_sof(in_sof), .wr_en(wr_en12), .wr_ready(wr_ready),
    .wr_addr(wr_addr12), .wr_data(wr_data12), .frame_done(frame_done12), .sync_err(sync_err12)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [11:0] px;
  } wr_t;

  wr_t q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  bit  in_frame = 0;
  int  pos = 0;
  bit  held = 0;
  int  hold_addr, hold_data;
  int  rdy_mode = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Channel bit = nibble >= threshold; B is bit 0, G bit 1, R bit 2.
  function automatic int quant(input logic [11:0] px, input int th);
    int r = 0;
    for (int c = 0; c < 3; c++)
      if (int'((px >> (4 * c)) & 12'hF) >= th) r += (1 << c);
    return r;
  endfunction

  // One clock cycle: entered just after a falling edge with inputs applied.
  task automatic tick(output bit acc);
    bit  fd_exp, se_exp, rst_now;
    wr_t e;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = 1'($urandom_range(0, 1));
      default: wr_ready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    rst_now = rst;
    fd_exp  = 0;
    se_exp  = 0;
    chk("in_ready_rule", int'(in_ready), int'(!wr_en || wr_ready));
    acc = in_valid && in_ready && !rst;
    if (rst_now) begin
      q.delete();
      in_frame = 0;
      pos      = 0;
      held     = 0;
    end else begin
      if (wr_en && wr_ready) begin
        if (q.size() == 0) begin
          chk("spurious_write", 1, 0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("wr_data", int'(wr_data), quant(e.px, 8));
          chk("wr_data_th12", int'(wr_data12), quant(e.px, 12));
          if (e.addr == NPIX - 1) fd_exp = 1;
        end
      end
      held      = wr_en && !wr_ready;
      hold_addr = int'(wr_addr);
      hold_data = int'(wr_data);
      if (acc) begin
        if (in_sof) begin
          se_exp = in_frame;
          q.push_back(wr_t'{0, in_pixel});
          pos      = 1;
          in_frame = (pos < NPIX);
        end else if (in_frame) begin
          q.push_back(wr_t'{pos, in_pixel});
          pos++;
          if (pos == NPIX) in_frame = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("frame_done", int'(frame_done), int'(fd_exp));
    chk("sync_err", int'(sync_err), int'(se_exp));
    chk("wr_en", int'(wr_en), int'(q.size() != 0));
    chk("wr_en_th12", int'(wr_en12), int'(q.size() != 0));
    if (held) begin
      chk("stall_addr_stable", int'(wr_addr), hold_addr);
      chk("stall_data_stable", int'(wr_data), hold_data);
    end
    if (rst_now) begin
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      chk("rst_in_ready", int'(in_ready), 1);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [11:0] px, input bit sof);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    in_pixel = px;
    in_sof   = sof;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    while (q.size() != 0 && n < 64) begin
      tick(acc);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    tick(acc);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_pixel = 12'($urandom);
    repeat (n) tick(acc);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  logic [11:0] frame [NPIX] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF,
                                12'h777, 12'h888, 12'h7FF, 12'h000};

  initial begin
    @(negedge clk);
    do_reset(2);

    // Directed full frame, no backpressure, then a stray pixel in IDLE
    rdy_mode = 0;
    for (int i = 0; i < NPIX; i++) send(frame[i], i == 0);
    drain();
    send(12'hFFF, 1'b0);
    idle(3);

    // Same frame under random backpressure
    rdy_mode = 1;
    for (int i = 0; i < NPIX; i++) send(frame[i], i == 0);
    drain();

    // Resync mid-frame, then finish the frame from address 1
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) send(frame[i], i == 0);
    send(12'hABC, 1'b1);
    for (int i = 1; i < NPIX; i++) send(frame[i], 1'b0);
    drain();

    // sof on the last-address pixel restarts instead of completing
    for (int i = 0; i < NPIX - 1; i++) send(frame[i], i == 0);
    send(12'h123, 1'b1);
    for (int i = 1; i < NPIX; i++) send(frame[i], 1'b0);
    drain();

    // Reset mid-stream, pre-sof discard, THRESH=12 corner pixel
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) send(frame[i], i == 0);
    do_reset(2);
    for (int i = 0; i < 5; i++) send(12'($urandom), 1'b0);
    send(12'hB0C, 1'b1);
    for (int i = 1; i < NPIX; i++) send(frame[i], 1'b0);
    drain();

    // Randomized frames with gaps, stray pixels and occasional resyncs
    for (int f = 0; f < 20; f++) begin
      rdy_mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) send(12'($urandom), 1'b0);
      for (int i = 0; i < NPIX; i++) begin
        if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        send(12'($urandom), (i == 0) || ($urandom_range(0, 15) == 0));
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
